// File: rtl/clock_phase_gen.sv
// Divides the board clock into processor/regfile/dmem clocks with a post-reset hold-off,
// a period-boundary stall and a count of completed processor periods.
module clock_phase_gen #(
    parameter int unsigned DIV         = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    output logic                    processor_clock,
    output logic                    regfile_clock,
    output logic                    dmem_clock,
    output logic                    running,
    output logic [$clog2(DIV)-1:0]  phase,
    output logic [CNT_W-1:0]        cycle_count
);

    localparam int unsigned PhW   = $clog2(DIV);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

    localparam logic [PhW-1:0]   PhLast   = PhW'(DIV - 1);
    localparam logic [PhW-1:0]   PhHalf   = PhW'(DIV / 2);
    localparam logic [PhW-1:0]   PhQuart  = PhW'(DIV / 4);
    localparam logic [PhW-1:0]   PhThreeQ = PhW'((3 * DIV) / 4);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StHold,
        StRun,
        StStall
    } state_e;

    state_e             state_q, state_d;
    logic [PhW-1:0]     phase_q, phase_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic run_d, pclk_d, dclk_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        count_d = count_q;
        unique case (state_q)
            StHold: begin
                hold_d  = hold_q + HoldW'(1);
                phase_d = '0;
                if (hold_q == HoldLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // stall only takes effect at the period boundary so no period is shortened
                if (phase_q == PhLast) begin
                    phase_d = '0;
                    count_d = count_q + CNT_W'(1);
                    if (stall) begin
                        state_d = StStall;
                    end
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StStall: begin
                phase_d = '0;
                if (!stall) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StHold;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are registered decodes of the next state so they match state/phase each cycle.
    always_comb begin
        run_d  = (state_d == StRun);
        pclk_d = run_d && (phase_d < PhHalf);
        dclk_d = run_d && (phase_d >= PhQuart) && (phase_d < PhThreeQ);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StHold;
            phase_q         <= '0;
            hold_q          <= '0;
            count_q         <= '0;
            processor_clock <= 1'b0;
            regfile_clock   <= 1'b0;
            dmem_clock      <= 1'b0;
            running         <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            hold_q          <= hold_d;
            count_q         <= count_d;
            processor_clock <= pclk_d;
            regfile_clock   <= pclk_d;
            dmem_clock      <= dclk_d;
            running         <= run_d;
        end
    end

    assign phase       = phase_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Scoreboard bench: driver pushes model expectations per clock, monitor checks on negedge.
module tb_clock_phase_gen;

    localparam int DIV  = 4;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;

    logic       pa, ra, da, runa;
    logic [1:0] pha;
    logic [31:0] cnta;
    logic       pb, rb, db, runb;
    logic [1:0] phb;
    logic [3:0] cntb;

    always #5 clk = ~clk;

    clock_phase_gen #(.DIV(DIV), .HOLD_CYCLES(HOLD), .CNT_W(32)) u_dut (
        .clock           (clk),
        .reset           (reset),
        .stall           (stall),
        .processor_clock (pa),
        .regfile_clock   (ra),
        .dmem_clock      (da),
        .running         (runa),
        .phase           (pha),
        .cycle_count     (cnta)
    );

    clock_phase_gen #(.DIV(DIV), .HOLD_CYCLES(HOLD), .CNT_W(4)) u_dut_w4 (
        .clock           (clk),
        .reset           (reset),
        .stall           (stall),
        .processor_clock (pb),
        .regfile_clock   (rb),
        .dmem_clock      (db),
        .running         (runb),
        .phase           (phb),
        .cycle_count     (cntb)
    );

    typedef struct packed {
        logic        pclk;
        logic        rclk;
        logic        dclk;
        logic        run;
        logic [1:0]  ph;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Abstract model: mode 0 = hold-off, 1 = running, 2 = stalled.
    int          m_mode  = 0;
    int          m_held  = 0;
    int          m_phase = 0;
    logic [31:0] m_cnt   = '0;

    task automatic model_update(input logic r, input logic s);
        if (r) begin
            m_mode = 0; m_held = 0; m_phase = 0; m_cnt = '0;
        end else if (m_mode == 0) begin
            m_held++;
            if (m_held == HOLD) begin
                m_mode = 1; m_phase = 0;
            end
        end else if (m_mode == 1) begin
            if (m_phase == DIV - 1) begin
                m_phase = 0;
                m_cnt = m_cnt + 32'd1;
                if (s) m_mode = 2;
            end else begin
                m_phase++;
            end
        end else if (!s) begin
            m_mode = 1; m_phase = 0;
        end
    endtask

    function automatic exp_t expected();
        exp_t e;
        e.run  = (m_mode == 1);
        e.pclk = e.run && (m_phase < DIV / 2);
        e.rclk = e.pclk;
        e.dclk = e.run && (m_phase >= DIV / 4) && (m_phase < (3 * DIV) / 4);
        e.ph   = 2'(m_phase);
        e.cnt  = m_cnt;
        return e;
    endfunction

    task automatic step(input logic r, input logic s);
        reset = r;
        stall = s;
        @(posedge clk);
        model_update(r, s);
        q.push_back(expected());
        #2;
    endtask

    task automatic idle_to_phase(input int target);
        for (int i = 0; i < 16 && !(m_mode == 1 && m_phase == target); i++) step(1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [9:0] act_b, exp_b;
            e = q.pop_front();
            n_tests++;
            if ({pa, ra, da, runa, pha, cnta} !== e) begin
                n_fail++;
                $display("FAIL main_outputs t=%0t: got p=%b r=%b d=%b run=%b ph=%0d cnt=%0d, expected p=%b r=%b d=%b run=%b ph=%0d cnt=%0d",
                         $time, pa, ra, da, runa, pha, cnta,
                         e.pclk, e.rclk, e.dclk, e.run, e.ph, e.cnt);
            end
            act_b = {pb, rb, db, runb, phb, cntb};
            exp_b = {e.pclk, e.rclk, e.dclk, e.run, e.ph, e.cnt[3:0]};
            n_tests++;
            if (act_b !== exp_b) begin
                n_fail++;
                $display("FAIL narrow_count_outputs t=%0t: got %b expected %b", $time, act_b, exp_b);
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0);
        // Hold-off then 10 clean periods
        repeat (HOLD + 10 * DIV) step(1'b0, 1'b0);
        // Stall raised and dropped mid-period has no effect
        idle_to_phase(1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        // Stall held across the period boundary
        idle_to_phase(3);
        repeat (5) step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        // Reset mid-period
        idle_to_phase(2);
        step(1'b1, 1'b0);
        // 17 periods to wrap the narrow counter
        repeat (HOLD + 17 * DIV + 3) step(1'b0, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, s;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 2) == 0);
            step(r, s);
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
